// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, funcMem codes and access-size decode
// for the load/store sequencer.
package lsu_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [2:0] FM_B  = 3'b000;
    localparam logic [2:0] FM_H  = 3'b001;
    localparam logic [2:0] FM_W  = 3'b010;
    localparam logic [2:0] FM_BU = 3'b100;
    localparam logic [2:0] FM_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_REQ1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_DONE  = 3'd5
    } lsu_state_e;

    // log2 of the access size in bytes; meaningful only for legal codes
    function automatic logic [1:0] fm_size_log2(input logic [2:0] func);
        return func[1:0];
    endfunction

    function automatic logic fm_legal(input logic [2:0] func, input logic is_write);
        logic ok;
        case (func)
            FM_B, FM_H, FM_W: ok = 1'b1;
            FM_BU, FM_HU:     ok = ~is_write;
            default:          ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane mask and shift for stores, lane extract and
// sign/zero extension for loads. Shared by both bus beats.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]          size_log2,
    input  logic [1:0]          offset,
    input  logic                sign_ext,
    input  logic [WORD_W-1:0]   st_data,
    input  logic [2*WORD_W-1:0] ld_raw,
    output logic [7:0]          lane_mask_c,
    output logic [2*WORD_W-1:0] st_lanes_c,
    output logic [WORD_W-1:0]   ld_data_c
);

    logic [4:0]        shamt;
    logic [7:0]        base_mask;
    logic [WORD_W-1:0] ld_shift;

    assign shamt = {offset, 3'b000};

    always_comb begin
        base_mask   = 8'b0000_1111;
        lane_mask_c = 8'h00;
        st_lanes_c  = '0;
        ld_shift    = '0;
        ld_data_c   = '0;
        case (size_log2)
            2'd0:    base_mask = 8'b0000_0001;
            2'd1:    base_mask = 8'b0000_0011;
            default: base_mask = 8'b0000_1111;
        endcase
        lane_mask_c = base_mask << offset;
        st_lanes_c  = {WORD_W'(0), st_data} << shamt;
        // low word of the shifted pair holds the addressed bytes
        ld_shift    = WORD_W'(ld_raw >> shamt);
        case (size_log2)
            2'd0:    ld_data_c = {{(WORD_W-8){sign_ext & ld_shift[7]}}, ld_shift[7:0]};
            2'd1:    ld_data_c = {{(WORD_W-16){sign_ext & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data_c = ld_shift;
        endcase
    end

endmodule

// File: rtl/lsu_sequencer.sv
// lsu_sequencer: sequences one load/store onto a req/gnt/rvalid memory bus.
// Define LSU_MISALIGNED_EN to split word-crossing accesses into two beats
// instead of flagging them as misaligned.
module lsu_sequencer
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic              op_write,
    input  logic [2:0]        func_mem,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] op_wdata,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] load_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    generate
        if (DATA_W != WORD_W) begin : g_bad_data_w
            $error("lsu_sequencer: DATA_W must be 32");
        end
    endgenerate

    lsu_state_e          state;
    logic                op_write_q, sign_ext_q, split_q;
    logic [1:0]          size_q, offset_q;
    logic [WORD_W-1:0]   wdata_q, beat0_q;

    logic                idle;
    logic [1:0]          size_in;
    logic                misaligned, split_in, bad_in;
    logic [1:0]          al_size, al_off;
    logic [WORD_W-1:0]   al_wdata, ld_data;
    logic [2*WORD_W-1:0] ld_raw, st_lanes;
    logic [7:0]          lane_mask;

    assign idle    = (state == ST_IDLE);
    assign size_in = fm_size_log2(func_mem);

`ifdef LSU_MISALIGNED_EN
    logic [3:0] acc_end;
    assign acc_end    = {2'b00, op_addr[1:0]} + (4'd1 << size_in);
    assign misaligned = 1'b0;
    assign split_in   = (acc_end > 4'd4);
`else
    assign misaligned = ((size_in == 2'd1) && op_addr[0])
                     || ((size_in == 2'd2) && (op_addr[1:0] != 2'b00));
    assign split_in   = 1'b0;
`endif

    assign bad_in = ~fm_legal(func_mem, op_write) | misaligned;

    // the aligner sees the incoming op in IDLE and the latched op afterwards
    assign al_size  = idle ? size_in : size_q;
    assign al_off   = idle ? op_addr[1:0] : offset_q;
    assign al_wdata = idle ? op_wdata : wdata_q;
    assign ld_raw   = (state == ST_WAIT1) ? {mem_rdata, beat0_q} : {WORD_W'(0), mem_rdata};

    lsu_align u_align (
        .size_log2   (al_size),
        .offset      (al_off),
        .sign_ext    (sign_ext_q),
        .st_data     (al_wdata),
        .ld_raw      (ld_raw),
        .lane_mask_c (lane_mask),
        .st_lanes_c  (st_lanes),
        .ld_data_c   (ld_data)
    );

    // reset also releases the pipeline so a flushed op does not hold it
    assign stall = op_valid & ~done & rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            load_data  <= '0;
            op_write_q <= 1'b0;
            sign_ext_q <= 1'b0;
            split_q    <= 1'b0;
            size_q     <= '0;
            offset_q   <= '0;
            wdata_q    <= '0;
            beat0_q    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (op_valid) begin
                    op_write_q <= op_write;
                    sign_ext_q <= ~func_mem[2];
                    split_q    <= split_in;
                    size_q     <= size_in;
                    offset_q   <= op_addr[1:0];
                    wdata_q    <= op_wdata;
                    if (bad_in) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        load_data <= '0;
                    end else begin
                        state     <= ST_REQ0;
                        mem_req   <= 1'b1;
                        mem_we    <= op_write;
                        mem_addr  <= {op_addr[ADDR_W-1:2], 2'b00};
                        mem_be    <= lane_mask[3:0];
                        mem_wdata <= st_lanes[WORD_W-1:0];
                    end
                end
                ST_REQ0, ST_REQ1: if (mem_gnt) begin
                    if (op_write_q && split_q && (state == ST_REQ0)) begin
                        state     <= ST_REQ1;
                        mem_addr  <= mem_addr + ADDR_W'(4);
                        mem_be    <= lane_mask[7:4];
                        mem_wdata <= st_lanes[2*WORD_W-1:WORD_W];
                    end else begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (op_write_q) begin
                            state     <= ST_DONE;
                            done      <= 1'b1;
                            err       <= 1'b0;
                            load_data <= '0;
                        end else begin
                            state <= (state == ST_REQ0) ? ST_WAIT0 : ST_WAIT1;
                        end
                    end
                end
                ST_WAIT0: if (mem_rvalid) begin
                    beat0_q <= mem_rdata;
                    if (split_q) begin
                        state    <= ST_REQ1;
                        mem_req  <= 1'b1;
                        mem_addr <= mem_addr + ADDR_W'(4);
                        mem_be   <= lane_mask[7:4];
                    end else begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        err       <= 1'b0;
                        load_data <= ld_data;
                    end
                end
                ST_WAIT1: if (mem_rvalid) begin
                    state     <= ST_DONE;
                    done      <= 1'b1;
                    err       <= 1'b0;
                    load_data <= ld_data;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_sequencer.sv
// tb_lsu_sequencer: directed and randomized loads/stores against a
// byte-addressed reference memory; the bench also acts as the bus slave.
module tb_lsu_sequencer;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        op_valid, op_write;
    logic [2:0]  func_mem;
    logic [31:0] op_addr, op_wdata;
    logic        stall, done, err;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .op_write   (op_write),
        .func_mem   (func_mem),
        .op_addr    (op_addr),
        .op_wdata   (op_wdata),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .load_data  (load_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] bus_mem [int unsigned];
    logic [7:0] ref_mem [int unsigned];

    typedef struct {
        int          lat;
        int          extra;
        int          beats;
        int          first_req;
        logic [31:0] a0, a1, w0;
        logic [3:0]  be0, be1;
        bit          stall_ok;
        bit          timeout;
    } obs_t;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : 8'h00;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
    endfunction

    function automatic int nbytes(input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            bus_mem[32'(a + i)] = w[8*i +: 8];
            ref_mem[32'(a + i)] = w[8*i +: 8];
        end
    endtask

    // present one op and play the bus slave until done (bounded)
    task automatic run_op(input logic wr, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] wd, input bit eager, output obs_t o);
        logic [31:0] rd_word;
        bit          rd_armed, g, rv;
        o.lat = 0; o.extra = 0; o.beats = 0; o.first_req = -1;
        o.a0 = '0; o.a1 = '0; o.w0 = '0; o.be0 = '0; o.be1 = '0;
        o.stall_ok = 1'b1; o.timeout = 1'b1;
        rd_armed = 1'b0;
        rd_word  = '0;
        @(negedge clk);
        op_valid = 1'b1; op_write = wr; func_mem = f; op_addr = a; op_wdata = wd;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            #1;
            if (done) begin
                o.lat = c;
                o.timeout = 1'b0;
                if (stall !== 1'b0) o.stall_ok = 1'b0;
                break;
            end
            if (stall !== 1'b1) o.stall_ok = 1'b0;
            if (mem_req && o.first_req < 0) o.first_req = c;
            g = mem_req && (eager || $urandom_range(0, 2) != 0);
            if (mem_req && !g) o.extra++;
            rv = 1'b0;
            if (rd_armed) begin
                rv = eager || ($urandom_range(0, 2) != 0);
                if (!rv) o.extra++;
            end
            mem_rvalid = rv || (!rd_armed && mem_req && !eager && $urandom_range(0, 3) == 0);
            mem_rdata  = rv ? rd_word : $urandom();
            mem_gnt    = g;
            if (rv) rd_armed = 1'b0;
            if (g) begin
                o.beats++;
                if (o.beats == 1) begin
                    o.a0 = mem_addr; o.be0 = mem_be; o.w0 = mem_wdata;
                end else begin
                    o.a1 = mem_addr; o.be1 = mem_be;
                end
                if (mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) bus_mem[32'(mem_addr + b)] = mem_wdata[8*b +: 8];
                end else begin
                    for (int b = 0; b < 4; b++) rd_word[8*b +: 8] = bus_rd(32'(mem_addr + b));
                    rd_armed = 1'b1;
                end
            end
            @(negedge clk);
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
        end
    endtask

    // reference: byte-granular memory semantics and bus-cycle accounting
    task automatic check_op(input logic wr, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] wd, input obs_t o);
        int          n, off;
        bit          bad, split;
        logic [31:0] exp_ld, base;
        logic [63:0] win_bus, win_ref;
        n     = nbytes(f);
        off   = int'(a[1:0]);
        bad   = (n == 0) || (wr && f[2]);
`ifdef LSU_MISALIGNED_EN
        split = !bad && (off + n > 4);
`else
        if (n != 0 && (off % n) != 0) bad = 1'b1;
        split = 1'b0;
`endif
        check_eq("timeout", 64'(o.timeout), 64'd0);
        check_eq("latency", 64'(o.lat),
                 64'(bad ? 1 : 1 + (split ? 2 : 1) * (wr ? 1 : 2) + o.extra));
        check_eq("err", 64'(err), 64'(bad));
        check_eq("stall", 64'(o.stall_ok), 64'd1);
        check_eq("beats", 64'(o.beats), 64'(bad ? 0 : (split ? 2 : 1)));
        if (bad) begin
            check_eq("no_req", 64'(o.first_req), 64'(-1));
        end else if (wr) begin
            for (int i = 0; i < n; i++) ref_mem[32'(a + i)] = wd[8*i +: 8];
            base = {a[31:2], 2'b00};
            for (int i = 0; i < 8; i++) begin
                win_bus[8*i +: 8] = bus_rd(32'(base + i));
                win_ref[8*i +: 8] = ref_rd(32'(base + i));
            end
            check_eq("store_mem", win_bus, win_ref);
        end else begin
            exp_ld = '0;
            for (int i = 0; i < n; i++) exp_ld[8*i +: 8] = ref_rd(32'(a + i));
            if (!f[2] && n < 4 && exp_ld[8*n-1]) exp_ld = exp_ld | ~((32'd1 << (8*n)) - 32'd1);
            check_eq("load_data", 64'(load_data), 64'(exp_ld));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        obs_t        o;
        logic        wr;
        logic [2:0]  f;
        logic [31:0] a, wd;
        int          r, ndone;

        rst_n = 1'b0; op_valid = 1'b0; op_write = 1'b0; func_mem = '0;
        op_addr = '0; op_wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_req", 64'(mem_req), 64'd0);
        check_eq("rst_we_done_err", 64'({mem_we, done, err}), 64'd0);
        check_eq("rst_addr", 64'(mem_addr), 64'd0);
        check_eq("rst_be_wdata", 64'({mem_be, mem_wdata}), 64'd0);
        check_eq("rst_load_data", 64'(load_data), 64'd0);
        rst_n = 1'b1;

        run_op(1'b1, FM_W, 32'h100, 32'h1234_5678, 1'b1, o);
        check_op(1'b1, FM_W, 32'h100, 32'h1234_5678, o);
        check_eq("sw_req_cycle", 64'(o.first_req), 64'd1);
        check_eq("sw_addr", 64'(o.a0), 64'h100);
        check_eq("sw_be", 64'(o.be0), 64'hF);
        check_eq("sw_wdata", 64'(o.w0), 64'h1234_5678);
        check_eq("sw_done_cycle", 64'(o.lat), 64'd2);

        preload(32'h100, 32'h80AA_BBCC);
        run_op(1'b0, FM_B, 32'h103, 32'h0, 1'b1, o);
        check_op(1'b0, FM_B, 32'h103, 32'h0, o);
        check_eq("lb_value", 64'(load_data), 64'hFFFF_FF80);
        check_eq("lb_done_cycle", 64'(o.lat), 64'd3);
        run_op(1'b0, FM_BU, 32'h103, 32'h0, 1'b1, o);
        check_op(1'b0, FM_BU, 32'h103, 32'h0, o);
        check_eq("lbu_value", 64'(load_data), 64'h0000_0080);

        run_op(1'b1, FM_H, 32'h102, 32'h1234_BEEF, 1'b1, o);
        check_op(1'b1, FM_H, 32'h102, 32'h1234_BEEF, o);
        check_eq("sh_be", 64'(o.be0), 64'hC);
        check_eq("sh_wdata", 64'(o.w0), 64'hBEEF_0000);

        preload(32'h0FC, 32'h1122_3344);
        preload(32'h100, 32'h5566_7788);
        run_op(1'b0, FM_W, 32'h0FE, 32'h0, 1'b1, o);
        check_op(1'b0, FM_W, 32'h0FE, 32'h0, o);
`ifdef LSU_MISALIGNED_EN
        check_eq("lw_split_beat0", 64'({o.a0, o.be0}), 64'({32'h0FC, 4'b1100}));
        check_eq("lw_split_beat1", 64'({o.a1, o.be1}), 64'({32'h100, 4'b0011}));
        check_eq("lw_split_value", 64'(load_data), 64'h7788_1122);
        check_eq("lw_split_cycle", 64'(o.lat), 64'd5);
`else
        check_eq("lw_misal_err", 64'(err), 64'd1);
        check_eq("lw_misal_cycle", 64'(o.lat), 64'd1);
`endif

        run_op(1'b0, 3'b011, 32'h104, 32'h0, 1'b1, o);
        check_op(1'b0, 3'b011, 32'h104, 32'h0, o);
        check_eq("illegal_err", 64'(err), 64'd1);
        check_eq("illegal_cycle", 64'(o.lat), 64'd1);

        // reset during REQ0 (s=0) and during WAIT0 (s=1) after gnt withheld
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            op_valid = 1'b1; op_write = 1'b0; func_mem = FM_W; op_addr = 32'h108;
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            repeat (4) @(negedge clk);
            #1;
            check_eq("hold_req", 64'(mem_req), 64'd1);
            if (s == 1) begin
                mem_gnt = 1'b1;
                @(negedge clk);
                mem_gnt = 1'b0;
                #1;
            end
            rst_n = 1'b0;
            #1;
            check_eq("rst_drop_req", 64'(mem_req), 64'd0);
            check_eq("rst_drop_stall", 64'(stall), 64'd0);
            @(negedge clk);
            rst_n = 1'b1;
            op_valid = 1'b0;
            @(negedge clk);
            mem_rvalid = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
            ndone = 0;
            repeat (4) begin
                @(negedge clk);
                mem_rvalid = 1'b0;
                #1;
                if (done) ndone++;
            end
            check_eq("late_rvalid_done", 64'(ndone), 64'd0);
        end

        for (int k = 0; k < 200; k++) begin
            wr = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 9));
            f  = (r < 8) ? 3'(r) : FM_W;
            a  = ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                              : 32'h100 + 32'($urandom_range(0, 63));
            wd = $urandom();
            run_op(wr, f, a, wd, 1'b0, o);
            check_op(wr, f, a, wd, o);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                op_valid = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_sequencer.md
# lsu_sequencer

Load/store sequencer between the execute stage and the data-memory port. It accepts one load or store from the decoded control (`funcMem`, ALU address, rs2 data) and drives a request/grant/response memory bus. It formats byte-lane enables and load data, and holds the pipeline with `stall` until the access completes. Accesses that cross a word boundary are split into two bus beats when misaligned support is compiled in.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width
- `DATA_W`, 32, bus data width; fixed at 32, any other value is a parameter error

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous, active-low reset
- `op_valid`  in  1  load/store present in execute; inputs held stable while `stall`=1
- `op_write`  in  1  1 = store, 0 = load
- `func_mem`  in  3  funcMem code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `op_addr`  in  32  byte address (ALU result)
- `op_wdata`  in  32  store data (rs2)
- `stall`  out  1  pipeline hold
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `done`; illegal func or misaligned access
- `load_data`  out  32  extended load result, valid with `done`
- `mem_req`  out  1  bus request
- `mem_we`  out  1  write enable
- `mem_addr`  out  32  word-aligned address, `[1:0]`=00
- `mem_be`  out  4  byte enables
- `mem_wdata`  out  32  lane-shifted write data
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rvalid`  in  1  read data valid; at least one cycle after its `gnt`
- `mem_rdata`  in  32  read data

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
- IDLE:
  - `op_valid` → latch op, compute size, offset = `op_addr[1:0]`, legality.
  - Illegal access → DONE with `err` set.
  - Otherwise → REQ0.
- REQ0/REQ1:
  - `mem_req`=1 until `mem_gnt`.
  - Store: gnt → REQ1 if a second beat is needed, else DONE.
  - Load: gnt → WAIT0 or WAIT1.
- WAIT0:
  - `mem_rvalid` → capture beat0, then → REQ1 if split, else DONE.
- WAIT1:
  - `mem_rvalid` → capture beat1, then → DONE.
- DONE: `done`=1 for one cycle, then → IDLE.
- Byte-lane arithmetic:
  - 8-bit mask: 0001/0011/1111 by size, shifted left by offset.
  - `mem_be` = mask[3:0] for beat0 and mask[7:4] for beat1.
  - beat1 `mem_addr` = beat0 address + 4, wrapping mod 2^32.
  - Write data: 64-bit `op_wdata << (8*offset)`; low word goes on beat0, high word on beat1.
  - Load: `{beat1, beat0} >> (8*offset)`, truncated to size, sign-extended (B, H) or zero-extended (BU, HU).
- Illegal: `func_mem` ∈ {011, 110, 111}, or `op_write` with func 100/101.
- Misalignment rules are under Configuration.
- `stall` = `op_valid` & ~`done`.
- `err` and `load_data` are held until the next `done`.

## Timing
- Reset values: state IDLE; `mem_req`, `mem_we`, `done`, `err` = 0; `mem_addr`, `mem_be`, `mem_wdata`, `load_data` = 0.
- Reset asserted mid-transaction drops `mem_req` immediately. An outstanding `rvalid` after reset is ignored.
- Bus outputs are registered: `mem_req` rises the cycle after acceptance in IDLE.
- Latency from `op_valid` (cycle 0) with zero-wait bus:
  - aligned store: `done` at cycle 2
  - aligned load: `done` at cycle 3
  - split store: `done` at cycle 3
  - split load: `done` at cycle 5
  - illegal access: `done` at cycle 1
- Each cycle `gnt`=0 in REQx or `rvalid`=0 in WAITx adds one cycle.
- `rvalid` arriving in a REQ state is ignored.

## Configuration
- `LSU_MISALIGNED_EN` defined:
  - Halfword/word accesses with offset+size ≤ 4 complete in one beat.
  - offset+size > 4 splits into two beats.
  - Only func legality raises `err`.
- Undefined:
  - H/HU with `addr[0]`≠0, or W with `addr[1:0]`≠0, is misaligned: `err`=1, no bus activity.
  - REQ1/WAIT1 are unreachable.

## Structure
- `lsu_pkg`: state enum, funcMem constants (`FM_B`, `FM_H`, `FM_W`, `FM_BU`, `FM_HU`), size decode function.
- Sub-module `lsu_align`: combinational store-lane shift/mask and load extract/extend, shared by both beats.

## Test plan
- SW 0x1234_5678 @0x100, gnt at once → REQ cycle 1, be=1111, addr=0x100; `done` cycle 2, `err`=0.
- LB @0x103, rdata=0x80AA_BBCC → `load_data`=0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- SH 0xBEEF @0x102 → be=1100, wdata=0xBEEF_0000.
- LW @0x0FE with macro: beats 0x0FC be=1100 and 0x100 be=0011; rdata 0x1122_3344, 0x5566_7788 → 0x7788_1122. Without macro → `done` cycle 1, `err`=1, no `mem_req`.
- `gnt` withheld 3 cycles, then `rst_n` low during WAIT0 → `mem_req` and `stall` drop, state IDLE; a late `rvalid` produces no `done`.
- `func_mem`=011 → `err`=1 at cycle 1, `mem_req` never asserted.
